// File: rtl/ws2812_strip_ctrl.sv
// ws2812_strip_ctrl: frame-level controller for a WS2812/SK6812 pixel chain.
// Takes one pixel at a time and scales it by a global brightness. Each pixel
// is then shifted out MSB-first as one-bit codes to the line driver. A
// low-level latch gap follows every frame, including frames aborted when the
// pixel source underruns.
module ws2812_strip_ctrl #(
  parameter int NUM_LEDS        = 64,
  parameter int NUM_CH          = 3,
  parameter int RESET_CYCLES    = 30000,
  parameter int UNDERRUN_CYCLES = 2000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [8*NUM_CH-1:0]   pixel_in,
  input  logic                  pixel_in_valid,
  output logic                  pixel_in_ready,
  input  logic [7:0]            brightness_in,
  input  logic                  driver_ready_in,
  output logic                  code_out,
  output logic                  code_out_valid,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic                  underrun_out
);

  localparam int PIXEL_W = 8 * NUM_CH;
  localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int BIT_W   = $clog2(PIXEL_W);
  localparam int GAP_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int TO_W    = (UNDERRUN_CYCLES > 1) ? $clog2(UNDERRUN_CYCLES) : 1;

  localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIXEL_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(UNDERRUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PIX,
    S_SCALE,
    S_SEND,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [LED_W-1:0]     led_cnt_q, led_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [PIXEL_W-1:0]   pix_q, pix_d;
  logic [7:0]           bright_q, bright_d;
  logic [PIXEL_W-1:0]   shreg_q, shreg_d;
  logic                 pixel_in_ready_q, pixel_in_ready_d;
  logic                 code_out_q, code_out_d;
  logic                 code_out_valid_q, code_out_valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 underrun_q, underrun_d;

  logic                 accept;
  logic                 handshake;
  logic [PIXEL_W-1:0]   scaled;

  assign accept    = pixel_in_valid && pixel_in_ready_q;
  assign handshake = code_out_valid_q && driver_ready_in;

  // Per-channel brightness scale: (c * (b + 1)) >> 8, so 255 is exact identity.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_scale
    logic [15:0] prod;
    assign prod = {8'd0, pix_q[gi*8 +: 8]} * ({8'd0, bright_q} + 16'd1);
    assign scaled[gi*8 +: 8] = 8'(prod >> 8);
  end

  // Next-state logic; every output is derived from the next state so it is registered.
  always_comb begin
    state_d      = state_q;
    led_cnt_d    = led_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    pix_d        = pix_q;
    bright_d     = bright_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          led_cnt_d = '0;
          pix_d     = pixel_in;
          bright_d  = brightness_in;
          state_d   = S_SCALE;
        end
      end
      S_WAIT_PIX: begin
        // A pixel arriving on the last timeout cycle still wins.
        if (accept) begin
          to_cnt_d  = '0;
          led_cnt_d = led_cnt_q + 1'b1;
          pix_d     = pixel_in;
          bright_d  = brightness_in;
          state_d   = S_SCALE;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d   = '0;
          underrun_d = 1'b1;
          state_d    = S_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_SCALE: begin
        shreg_d   = scaled;
        bit_cnt_d = BIT_LAST;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == '0) begin
            state_d = (led_cnt_q == LED_LAST) ? S_GAP : S_WAIT_PIX;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        // Only count while the driver is idle so the last bit is fully on the wire.
        if (driver_ready_in) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d    = '0;
            led_cnt_d    = '0;
            to_cnt_d     = '0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pixel_in_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT_PIX);
    code_out_valid_d = (state_d == S_SEND);
    code_out_d       = (state_d == S_SEND) ? shreg_d[PIXEL_W-1] : 1'b0;
    busy_d           = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= S_IDLE;
      led_cnt_q        <= '0;
      bit_cnt_q        <= '0;
      gap_cnt_q        <= '0;
      to_cnt_q         <= '0;
      pix_q            <= '0;
      bright_q         <= '0;
      shreg_q          <= '0;
      pixel_in_ready_q <= 1'b0;
      code_out_q       <= 1'b0;
      code_out_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      underrun_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      led_cnt_q        <= led_cnt_d;
      bit_cnt_q        <= bit_cnt_d;
      gap_cnt_q        <= gap_cnt_d;
      to_cnt_q         <= to_cnt_d;
      pix_q            <= pix_d;
      bright_q         <= bright_d;
      shreg_q          <= shreg_d;
      pixel_in_ready_q <= pixel_in_ready_d;
      code_out_q       <= code_out_d;
      code_out_valid_q <= code_out_valid_d;
      busy_q           <= busy_d;
      frame_done_q     <= frame_done_d;
      underrun_q       <= underrun_d;
    end
  end

  assign pixel_in_ready = pixel_in_ready_q;
  assign code_out       = code_out_q;
  assign code_out_valid = code_out_valid_q;
  assign busy_out       = busy_q;
  assign frame_done_out = frame_done_q;
  assign underrun_out   = underrun_q;

endmodule

// File: tb/tb_ws2812_strip_ctrl.sv
// Testbench for ws2812_strip_ctrl: 4-LED GRB chain with short gap/timeout.
// Expected code bits are queued on pixel acceptance and popped on each
// code handshake; frame timing is checked against the last-bit cycle.
module tb_ws2812_strip_ctrl;

  localparam int NL = 4;
  localparam int NCH = 3;
  localparam int PW = 8 * NCH;
  localparam int RC = 40;
  localparam int UC = 20;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          pixel_in_valid = 1'b0;
  logic          pixel_in_ready;
  logic [7:0]    brightness_in = 8'd0;
  logic          driver_ready_in = 1'b1;
  logic          code_out;
  logic          code_out_valid;
  logic          busy_out;
  logic          frame_done_out;
  logic          underrun_out;

  ws2812_strip_ctrl #(
    .NUM_LEDS(NL), .NUM_CH(NCH), .RESET_CYCLES(RC), .UNDERRUN_CYCLES(UC)
  ) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .pixel_in_ready(pixel_in_ready),
    .brightness_in(brightness_in), .driver_ready_in(driver_ready_in),
    .code_out(code_out), .code_out_valid(code_out_valid),
    .busy_out(busy_out), .frame_done_out(frame_done_out), .underrun_out(underrun_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [PW-1:0] pix;
    logic [7:0]    br;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t tbl[12];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   underrun_cnt = 0;
  bit   stall_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic prev_code = 1'b0;
  bit   sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [PW-1:0] p, input logic [7:0] b);
    logic [PW-1:0] r;
    for (int ch = 0; ch < NCH; ch++) begin
      int c;
      c = int'(p[ch*8 +: 8]);
      r[ch*8 +: 8] = 8'((c * (int'(b) + 1)) >> 8);
    end
    return r;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // Driver readiness: always ready unless random stalls are enabled.
  always @(posedge clk_in) begin
    #1;
    driver_ready_in = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: bit scoreboard, stall hold, ready/valid exclusivity.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", 32'(code_out_valid), 32'd1);
        check("stall_code_hold", 32'(code_out), 32'(prev_code));
      end
      if (code_out_valid) check("ready_during_send", 32'(pixel_in_ready), 32'd0);
      if (code_out_valid && driver_ready_in) begin
        check("bit_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          bit want;
          want = sb.pop_front();
          check("code_bit", 32'(code_out), 32'(want));
          $display("bit cyc=%0d code=%0b want=%0b", cyc, code_out, want);
        end
        last_hs = cyc;
      end
      prev_stall = code_out_valid && !driver_ready_in;
      prev_code  = code_out;
      if (underrun_out) underrun_cnt++;
    end
  end

  task automatic push_bits(input logic [PW-1:0] v);
    for (int i = PW - 1; i >= 0; i--) sb.push_back(v[i]);
  endtask

  task automatic send_pixel(input logic [PW-1:0] p, input logic [7:0] b,
                            input logic [PW-1:0] exp, input bit chk_lat);
    bit ok;
    ok = 1'b0;
    @(posedge clk_in); #1;
    pixel_in = p; brightness_in = b; pixel_in_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_in);
      if (pixel_in_ready) begin ok = 1'b1; break; end
    end
    check("accept_seen", 32'(ok), 32'd1);
    if (ok) begin
      push_bits(exp);
      $display("pixel %06h br=%0d exp=%06h", p, b, exp);
    end
    @(posedge clk_in); #1;
    pixel_in_valid = 1'b0;
    if (ok && chk_lat) begin
      @(negedge clk_in); check("lat_scale_valid", 32'(code_out_valid), 32'd0);
      @(negedge clk_in); check("lat_send_valid", 32'(code_out_valid), 32'd1);
    end
  endtask

  // want_off < 0 skips the timing check (used when the driver stalls).
  task automatic wait_done(input int want_off);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_in);
      if (frame_done_out) begin seen = 1'b1; break; end
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      $display("frame done cyc=%0d offset=%0d", cyc, cyc - last_hs);
      if (want_off >= 0) check("done_offset", 32'(cyc - last_hs), 32'(want_off));
      check("busy_at_done", 32'(busy_out), 32'd0);
      check("ready_at_done", 32'(pixel_in_ready), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);
      @(negedge clk_in);
      check("done_pulse_width", 32'(frame_done_out), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(pixel_in_ready), 32'd0);
    check({tag, "_valid"}, 32'(code_out_valid), 32'd0);
    check({tag, "_code"}, 32'(code_out), 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_done"}, 32'(frame_done_out), 32'd0);
    check({tag, "_underrun"}, 32'(underrun_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    bit seen;
    logic [PW-1:0] rp;
    logic [7:0] rb;

    tbl[0]  = '{24'hCCCF00, 8'd255, 24'hCCCF00};
    tbl[1]  = '{24'hCCCF00, 8'd127, 24'h666700};
    tbl[2]  = '{24'hCCCF00, 8'd0,   24'h000000};
    tbl[3]  = '{24'hFFFFFF, 8'd1,   24'h010101};
    tbl[4]  = '{24'h80FF01, 8'd128, 24'h408000};
    tbl[5]  = '{24'hFF00FF, 8'd254, 24'hFE00FE};
    tbl[6]  = '{24'h123456, 8'd255, 24'h123456};
    tbl[7]  = '{24'hFFFFFF, 8'd0,   24'h000000};
    tbl[8]  = '{24'h010203, 8'd255, 24'h010203};
    tbl[9]  = '{24'h040506, 8'd255, 24'h040506};
    tbl[10] = '{24'h070809, 8'd255, 24'h070809};
    tbl[11] = '{24'h0A0B0C, 8'd255, 24'h0A0B0C};

    // Reset state
    repeat (2) @(negedge clk_in);
    check_all_zero("reset");
    rst_n_in = 1'b1;

    // Two table-driven frames with unity/partial/zero brightness
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NL; i++)
        send_pixel(tbl[f*NL+i].pix, tbl[f*NL+i].br, tbl[f*NL+i].exp, i == 0);
      wait_done(RC + 1);
    end

    // Underrun: second pixel withheld
    send_pixel(24'h112233, 8'd255, 24'h112233, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk_in);
      if (underrun_out) begin seen = 1'b1; break; end
    end
    check("underrun_seen", 32'(seen), 32'd1);
    if (seen) begin
      $display("underrun cyc=%0d offset=%0d", cyc, cyc - last_hs);
      check("underrun_offset", 32'(cyc - last_hs), 32'(UC + 1));
      check("underrun_busy", 32'(busy_out), 32'd1);
      check("underrun_gap_ready", 32'(pixel_in_ready), 32'd0);
    end
    wait_done(UC + 1 + RC);

    // Pixel presented on the final timeout cycle is accepted
    u0 = underrun_cnt;
    send_pixel(24'hA1B2C3, 8'd255, 24'hA1B2C3, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk_in);
      if (sb.size() == 0 && !code_out_valid) begin seen = 1'b1; break; end
    end
    check("first_pixel_drained", 32'(seen), 32'd1);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk_in); #1;
      if (cyc == last_hs + UC) break;
    end
    pixel_in = 24'hD4E5F6; brightness_in = 8'd255; pixel_in_valid = 1'b1;
    @(negedge clk_in);
    check("final_cycle_ready", 32'(pixel_in_ready), 32'd1);
    check("final_cycle_no_underrun", 32'(underrun_out), 32'd0);
    if (pixel_in_ready) push_bits(24'hD4E5F6);
    @(posedge clk_in); #1;
    pixel_in_valid = 1'b0;
    send_pixel(24'h0F0F0F, 8'd255, 24'h0F0F0F, 1'b0);
    send_pixel(24'hF0F0F0, 8'd255, 24'hF0F0F0, 1'b0);
    wait_done(RC + 1);
    check("no_underrun_count", 32'(underrun_cnt - u0), 32'd0);

    // Random driver stalls
    stall_en = 1'b1;
    for (int i = 0; i < NL; i++) begin
      rp = PW'($urandom);
      rb = 8'($urandom_range(0, 255));
      send_pixel(rp, rb, model(rp, rb), 1'b0);
    end
    wait_done(-1);
    stall_en = 1'b0;

    // Reset mid-SEND, then a clean back-to-back frame
    send_pixel(24'h55AA55, 8'd255, 24'h55AA55, 1'b0);
    repeat (6) @(negedge clk_in);
    check("midsend_valid", 32'(code_out_valid), 32'd1);
    #1 rst_n_in = 1'b0;
    #1;
    check_all_zero("midsend_reset");
    sb.delete();
    repeat (2) @(negedge clk_in);
    check_all_zero("held_reset");
    rst_n_in = 1'b1;
    for (int i = 8; i < 12; i++)
      send_pixel(tbl[i].pix, tbl[i].br, tbl[i].exp, i == 8);
    wait_done(RC + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
